// File: rtl/uart_frame_assembler_if.sv
// Byte-in / frame-out bundle between the UART byte receiver, the frame assembler
// and the message consumer.
interface uart_frame_assembler_if #(
  parameter int unsigned HEADER_SIZE  = 32,
  parameter int unsigned MESSAGE_SIZE = 512
);
  logic                    byte_valid_in;
  logic [7:0]              byte_in;
  logic                    frame_valid_out;
  logic                    frame_ready_in;
  logic [HEADER_SIZE-1:0]  header_out;
  logic [MESSAGE_SIZE-1:0] message_out;
  logic                    overflow_out;
  logic                    timeout_out;

  modport master (
    output byte_valid_in, byte_in, frame_ready_in,
    input  frame_valid_out, header_out, message_out, overflow_out, timeout_out
  );

  modport slave (
    input  byte_valid_in, byte_in, frame_ready_in,
    output frame_valid_out, header_out, message_out, overflow_out, timeout_out
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// Assembles UART bytes MSB-first into header+body frames and presents them on a
// double-buffered valid/ready output; an inter-byte timeout drops partial frames.
module uart_frame_assembler #(
  parameter int unsigned HEADER_SIZE    = 32,
  parameter int unsigned MESSAGE_SIZE   = 512,
  parameter int unsigned TIMEOUT_CYCLES = 10_000
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  uart_frame_assembler_if.slave  bus
);
  localparam int unsigned HB    = HEADER_SIZE / 8;
  localparam int unsigned MB    = MESSAGE_SIZE / 8;
  localparam int unsigned TB    = HB + MB;
  localparam int unsigned SR_W  = TB * 8;
  localparam int unsigned CNT_W = $clog2(TB + 1);
  localparam int unsigned TO_W  = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_HEADER = 2'd1;
  localparam logic [1:0] S_BODY   = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TB - 1);
  localparam logic [CNT_W-1:0] CNT_HB   = CNT_W'(HB);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);

  logic [1:0]              state;
  logic [CNT_W-1:0]        count;
  logic [CNT_W-1:0]        count_inc;
  logic [TO_W-1:0]         idle_cnt;
  logic [SR_W-1:0]         shift_reg;
  logic [SR_W-1:0]         shift_next;
  logic                    frame_done;
  logic                    load;
  logic                    expire;

  logic                    frame_valid;
  logic [HEADER_SIZE-1:0]  header_q;
  logic [MESSAGE_SIZE-1:0] message_q;
  logic                    overflow_q;
  logic                    timeout_q;

  always_comb begin
    shift_next = {shift_reg[SR_W-9:0], bus.byte_in};
    count_inc  = count + CNT_ONE;
    frame_done = bus.byte_valid_in && (count == CNT_LAST);
    // The output buffer is free if empty or being drained on this very edge.
    load       = frame_done && (!frame_valid || bus.frame_ready_in);
    // A strobe on the expiry cycle takes priority over the timeout.
    expire     = (state != S_IDLE) && !bus.byte_valid_in && (idle_cnt == TO_LAST);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state     <= S_IDLE;
      count     <= '0;
      idle_cnt  <= '0;
      shift_reg <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      if (bus.byte_valid_in) begin
        shift_reg <= shift_next;
        idle_cnt  <= '0;
        if (frame_done) begin
          count <= '0;
          state <= S_IDLE;
        end else begin
          count <= count_inc;
          state <= (count_inc >= CNT_HB) ? S_BODY : S_HEADER;
        end
      end else if (state != S_IDLE) begin
        if (expire) begin
          count     <= '0;
          idle_cnt  <= '0;
          state     <= S_IDLE;
          timeout_q <= 1'b1;
        end else begin
          idle_cnt <= idle_cnt + TO_ONE;
        end
      end else begin
        idle_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_valid <= 1'b0;
      header_q    <= '0;
      message_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      overflow_q <= 1'b0;
      if (load) begin
        frame_valid <= 1'b1;
        header_q    <= shift_next[SR_W-1 -: HEADER_SIZE];
        message_q   <= shift_next[MESSAGE_SIZE-1:0];
      end else begin
        if (frame_done) overflow_q <= 1'b1;
        if (frame_valid && bus.frame_ready_in) frame_valid <= 1'b0;
      end
    end
  end

  assign bus.frame_valid_out = frame_valid;
  assign bus.header_out      = header_q;
  assign bus.message_out     = message_q;
  assign bus.overflow_out    = overflow_q;
  assign bus.timeout_out     = timeout_q;
endmodule
